// File: rtl/seq_alu_pkg.sv
// +--------------------------------------------------------------------+
// | alu_pkg: shared ALU operation codes and sequencer state encoding.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_MUL = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_alu_if.sv
// +--------------------------------------------------------------------+
// | seq_alu_if: request/response bundle between controller and ALU.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic                       start;
   logic [3:0]                 alucontrol;
   logic                       sign;
   logic [WIDTH-1:0]           a;
   logic [WIDTH-1:0]           b;
   logic [$clog2(WIDTH)-1:0]   shamt;
   logic                       busy;
   logic                       done;
   logic [WIDTH-1:0]           result;
   logic [WIDTH-1:0]           result_hi;
   logic                       zero;
   logic                       overflow;
   logic                       illegal;

   modport master (
      output start, alucontrol, sign, a, b, shamt,
      input  busy, done, result, result_hi, zero, overflow, illegal
   );

   modport slave (
      input  start, alucontrol, sign, a, b, shamt,
      output busy, done, result, result_hi, zero, overflow, illegal
   );
endinterface

`default_nettype wire

// File: rtl/seq_alu_mul_iter.sv
// +--------------------------------------------------------------------+
// | mul_iter: unsigned shift-add multiplier, one partial product/cycle.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mul_iter #(
   parameter int WIDTH = 32
) (
   input  wire logic                 clk,
   input  wire logic                 rst_n,
   input  wire logic                 load,
   input  wire logic                 step,
   input  wire logic [WIDTH-1:0]     mcand_in,
   input  wire logic [WIDTH-1:0]     mplier_in,
   output logic                      last,
   output logic [2*WIDTH-1:0]        product
);
   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH:0]     sum;

   // Multiplier sits in the low half of acc and drains out as the high half fills.
   always_comb begin
      sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
      product = {sum, acc_q[WIDTH-1:1]};
      last    = (cnt_q == CW'(WIDTH - 1));
      acc_d   = acc_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;
      if (load) begin
         acc_d   = {{WIDTH{1'b0}}, mplier_in};
         mcand_d = mcand_in;
         cnt_d   = '0;
      end else if (step) begin
         acc_d = product;
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
      end else begin
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// +--------------------------------------------------------------------+
// | seq_alu: single-cycle ALU ops plus a WIDTH-cycle signed/unsigned   |
// | multiply behind a start/busy/done handshake.  Rev 1.0              |
// +--------------------------------------------------------------------+
`default_nettype none

module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  wire logic  clk,
   input  wire logic  rst_n,
   seq_alu_if.slave   bus
);
   localparam int MSB = WIDTH - 1;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [WIDTH-1:0]   result_hi_q, result_hi_d;
   logic               zero_q, zero_d;
   logic               overflow_q, overflow_d;
   logic               illegal_q, illegal_d;
   logic               neg_q, neg_d;

   logic               mul_load, mul_step, mul_last;
   logic [2*WIDTH-1:0] mul_product, mul_signed;
   logic [WIDTH-1:0]   mag_a, mag_b, sum, diff, alu_res;
   logic               alu_ovf, alu_ill, lt;

   always_comb begin
      sum     = bus.a + bus.b;
      diff    = bus.a - bus.b;
      lt      = bus.sign ? ($signed(bus.a) < $signed(bus.b)) : (bus.a < bus.b);
      mag_a   = (bus.sign && bus.a[MSB]) ? -bus.a : bus.a;
      mag_b   = (bus.sign && bus.b[MSB]) ? -bus.b : bus.b;
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_ill = 1'b0;
      case (bus.alucontrol)
         ALU_AND: alu_res = bus.a & bus.b;
         ALU_OR:  alu_res = bus.a | bus.b;
         ALU_NOR: alu_res = ~(bus.a | bus.b);
         ALU_SLL: alu_res = bus.b << bus.shamt;
         ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, lt};
         ALU_ADD: begin
            alu_res = sum;
            alu_ovf = bus.sign && (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
         end
         ALU_SUB: begin
            alu_res = diff;
            alu_ovf = bus.sign && (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
         end
         ALU_MUL: alu_res = '0;
         default: alu_ill = 1'b1;
      endcase
   end

   mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (mul_load),
      .step      (mul_step),
      .mcand_in  (mag_a),
      .mplier_in (mag_b),
      .last      (mul_last),
      .product   (mul_product)
   );

   assign mul_signed = neg_q ? -mul_product : mul_product;

   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      zero_d      = zero_q;
      overflow_d  = overflow_q;
      illegal_d   = illegal_q;
      neg_d       = neg_q;
      mul_load    = 1'b0;
      mul_step    = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.start) begin
               if (bus.alucontrol == ALU_MUL) begin
                  mul_load = 1'b1;
                  neg_d    = bus.sign && (bus.a[MSB] ^ bus.b[MSB]);
                  state_d  = MUL;
               end else begin
                  result_d    = alu_res;
                  result_hi_d = '0;
                  zero_d      = (alu_res == '0);
                  overflow_d  = alu_ovf;
                  illegal_d   = alu_ill;
                  state_d     = DONE;
               end
            end
         end
         MUL: begin
            mul_step = 1'b1;
            // Product after the final step is written in the same edge that enters DONE.
            if (mul_last) begin
               result_d    = mul_signed[WIDTH-1:0];
               result_hi_d = mul_signed[2*WIDTH-1:WIDTH];
               zero_d      = (mul_signed[WIDTH-1:0] == '0);
               overflow_d  = 1'b0;
               illegal_d   = 1'b0;
               state_d     = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         result_q    <= '0;
         result_hi_q <= '0;
         zero_q      <= 1'b1;
         overflow_q  <= 1'b0;
         illegal_q   <= 1'b0;
         neg_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         zero_q      <= zero_d;
         overflow_q  <= overflow_d;
         illegal_q   <= illegal_d;
         neg_q       <= neg_d;
      end
   end

   assign bus.busy      = (state_q == MUL);
   assign bus.done      = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.result_hi = result_hi_q;
   assign bus.zero      = zero_q;
   assign bus.overflow  = overflow_q;
   assign bus.illegal   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// +--------------------------------------------------------------------+
// | tb_seq_alu: directed vector table plus multiply/reset sequences.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_seq_alu;
   import alu_pkg::*;

   localparam int W = 32;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   seq_alu_if #(.WIDTH(W)) bus ();

   seq_alu #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [31:0] res;
      logic        z;
      logic        ov;
      logic        il;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(string n, logic [3:0] op, logic sgn, logic [31:0] a,
                               logic [31:0] b, logic [4:0] sh, logic [31:0] res,
                               logic z, logic ov, logic il);
      vec_t v;
      v.name = n; v.op = op; v.sgn = sgn; v.a = a; v.b = b; v.sh = sh;
      v.res = res; v.z = z; v.ov = ov; v.il = il;
      return v;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
      bus.start      = 1'b1;
      bus.alucontrol = op;
      bus.sign       = sgn;
      bus.a          = a;
      bus.b          = b;
      bus.shamt      = sh;
   endtask

   // Issue a MUL, count edges until done, and check latency and product.
   task automatic run_mul(input string nm, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input bit poke);
      int cyc;
      @(negedge clk);
      drive(ALU_MUL, sgn, a, b, 5'd0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      check({nm, "_busy"}, {63'd0, bus.busy}, 64'd1);
      cyc = 1;
      while (!bus.done && cyc < 40) begin
         if (poke && cyc == 3) drive(ALU_ADD, 1'b0, 32'd1, 32'd1, 5'd0);
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (!bus.done) cyc++;
      end
      check({nm, "_latency"}, 64'(cyc), 64'(W));
      check({nm, "_product"}, {bus.result_hi, bus.result}, exp);
      check({nm, "_zero"}, {63'd0, bus.zero}, {63'd0, (exp[31:0] == 32'd0)});
   endtask

   initial begin
      rst_n = 1'b0;
      drive(ALU_AND, 1'b0, '0, '0, '0);
      bus.start = 1'b0;

      vecs[0]  = mk("add_ovf_s",  ALU_ADD, 1, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 0, 1, 0);
      vecs[1]  = mk("add_ovf_u",  ALU_ADD, 0, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 0, 0, 0);
      vecs[2]  = mk("sub_ovf_s",  ALU_SUB, 1, 32'h80000000, 32'h1, 0, 32'h7FFFFFFF, 0, 1, 0);
      vecs[3]  = mk("sub_zero",   ALU_SUB, 0, 32'h5, 32'h5, 0, 32'h0, 1, 0, 0);
      vecs[4]  = mk("and",        ALU_AND, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hF000F000, 0, 0, 0);
      vecs[5]  = mk("or",         ALU_OR,  0, 32'h0F0F0000, 32'h000000F0, 0, 32'h0F0F00F0, 0, 0, 0);
      vecs[6]  = mk("nor",        ALU_NOR, 0, 32'h0, 32'h0, 0, 32'hFFFFFFFF, 0, 0, 0);
      vecs[7]  = mk("slt_s",      ALU_SLT, 1, 32'hFFFFFFFF, 32'h1, 0, 32'h1, 0, 0, 0);
      vecs[8]  = mk("slt_u",      ALU_SLT, 0, 32'hFFFFFFFF, 32'h1, 0, 32'h0, 1, 0, 0);
      vecs[9]  = mk("sll31",      ALU_SLL, 0, 32'h0, 32'h1, 31, 32'h80000000, 0, 0, 0);
      vecs[10] = mk("illegal",    4'b1010, 0, 32'h12345678, 32'h9, 0, 32'h0, 1, 0, 1);
      vecs[11] = mk("add_wrap_s", ALU_ADD, 1, 32'hFFFFFFFF, 32'h1, 0, 32'h0, 1, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {63'd0, bus.busy}, 64'd0);
      check("rst_done", {63'd0, bus.done}, 64'd0);
      check("rst_result", {bus.result_hi, bus.result}, 64'd0);
      check("rst_flags", {61'd0, bus.zero, bus.overflow, bus.illegal}, 64'b100);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].sh);
         @(posedge clk); #1;
         bus.start = 1'b0;
         check({vecs[i].name, "_done"}, {63'd0, bus.done}, 64'd1);
         check({vecs[i].name, "_res"}, {bus.result_hi, bus.result}, {32'd0, vecs[i].res});
         check({vecs[i].name, "_flags"}, {61'd0, bus.zero, bus.overflow, bus.illegal},
               {61'd0, vecs[i].z, vecs[i].ov, vecs[i].il});
         @(posedge clk); #1;
         check({vecs[i].name, "_pulse"}, {63'd0, bus.done}, 64'd0);
      end

      run_mul("mul_neg3x5_s", 1'b1, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b0);
      run_mul("mul_neg3x5_u", 1'b0, 32'hFFFFFFFD, 32'd5, 64'h00000004_FFFFFFF1, 1'b0);
      run_mul("mul_min_sq",   1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b1);

      // Back-to-back: start presented in the DONE cycle must be taken.
      drive(ALU_ADD, 1'b0, 32'd2, 32'd3, 5'd0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("done_b2b_done", {63'd0, bus.done}, 64'd1);
      check("done_b2b_res", {bus.result_hi, bus.result}, 64'd5);

      // Reset in the middle of a multiply.
      @(negedge clk);
      drive(ALU_MUL, 1'b0, 32'd7, 32'd9, 5'd0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {63'd0, bus.busy}, 64'd0);
      check("midrst_result", {bus.result_hi, bus.result}, 64'd0);
      check("midrst_zero", {63'd0, bus.zero}, 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int pulses;
         pulses = 0;
         repeat (40) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) pulses++;
         end
         check("midrst_no_done", 64'(pulses), 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
